// File: rtl/mem_stage_hs.sv
// Memory-access pipeline stage between EX and WB.
// Latches the EX bundle, waits on a variable-latency SRAM load response,
// aligns/extends sub-word load data and drives the WB and ID-forwarding buses.
// A load still waiting for its data holds this stage's register by itself, so
// the entry cannot be overwritten or bubbled away while stall_req is high.
module mem_stage_hs #(
  parameter int PC_W    = 32,
  parameter int RF_AW   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_mem,
  input  logic             stall_wb,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_mem_en,
  input  logic [3:0]       ex_mem_we,
  input  logic [2:0]       ex_ld_type,
  input  logic [31:0]      ex_addr,
  input  logic             ex_rf_we,
  input  logic [RF_AW-1:0] ex_rf_waddr,
  input  logic [31:0]      ex_result,
  input  logic             data_rsp_valid,
  input  logic [31:0]      data_sram_rdata,
  output logic             stall_req,
  output logic             wb_valid,
  output logic [PC_W-1:0]  wb_pc,
  output logic             wb_rf_we,
  output logic [RF_AW-1:0] wb_rf_waddr,
  output logic [31:0]      wb_rf_wdata,
  output logic             fwd_we,
  output logic [RF_AW-1:0] fwd_waddr,
  output logic [31:0]      fwd_wdata,
  output logic             fwd_load_pending,
  output logic             mem_err
);

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no response outstanding
    S_WAIT = 2'd1,  // load in the register, response not yet seen
    S_HOLD = 2'd2   // response buffered while WB is stalled
  } state_e;

  // Only the byte lane of the address matters here; the SRAM was addressed in EX.
  typedef struct packed {
    logic             valid;
    logic [PC_W-1:0]  pc;
    logic             mem_en;
    logic [3:0]       mem_we;
    logic [2:0]       ld_type;
    logic [1:0]       lane;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [31:0]      result;
  } entry_t;

  entry_t           ent_q, ent_d, ex_ent;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rsp_buf_q, rsp_buf_d;
  logic             mem_err_q, mem_err_d;
  logic             is_load, pending, timeout_hit;
  logic [31:0]      raw_word, load_data, wdata;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^ex_addr[31:2];

  // Pick the addressed lane(s) and extend; undefined types behave as LW and
  // misaligned halves/words simply use the aligned lanes.
  function automatic logic [31:0] align_load(input logic [31:0] w,
                                             input logic [2:0]  t,
                                             input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (t)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'b0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Pack the incoming EX bundle into an entry.
  always_comb begin
    ex_ent          = '0;
    ex_ent.valid    = ex_valid;
    ex_ent.pc       = ex_pc;
    ex_ent.mem_en   = ex_mem_en;
    ex_ent.mem_we   = ex_mem_we;
    ex_ent.ld_type  = ex_ld_type;
    ex_ent.lane     = ex_addr[1:0];
    ex_ent.rf_we    = ex_rf_we;
    ex_ent.rf_waddr = ex_rf_waddr;
    ex_ent.result   = ex_result;
  end

  assign is_load     = ent_q.valid & ent_q.mem_en & (ent_q.mem_we == 4'b0);
  assign timeout_hit = (state_q == S_WAIT) & ~data_rsp_valid &
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  // Response FSM: next state, wait counter, response buffer and data source.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rsp_buf_d = rsp_buf_q;
    raw_word  = data_sram_rdata;
    pending   = 1'b0;
    mem_err_d = mem_err_q | timeout_hit;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (is_load) begin
          if (data_rsp_valid) begin
            rsp_buf_d = data_sram_rdata;
            if (stall_wb) state_d = S_HOLD;
          end else begin
            pending = 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (data_rsp_valid) begin
          rsp_buf_d = data_sram_rdata;
          cnt_d     = '0;
          state_d   = stall_wb ? S_HOLD : S_IDLE;
        end else if (timeout_hit) begin
          // Give up: complete the load with zero data.
          raw_word  = '0;
          rsp_buf_d = '0;
          cnt_d     = '0;
          state_d   = stall_wb ? S_HOLD : S_IDLE;
        end else begin
          pending = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        // Further responses are ignored; the buffered word is the result.
        raw_word = rsp_buf_q;
        if (!stall_wb) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Input register update: flush > own load stall > bubble > capture > hold.
  always_comb begin
    ent_d = ent_q;
    if (flush) begin
      ent_d.valid = 1'b0;
    end else if (!pending) begin
      if (stall_mem && !stall_wb) ent_d.valid = 1'b0;
      else if (!stall_mem)        ent_d = ex_ent;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      ent_q     <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rsp_buf_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      ent_q     <= ent_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_buf_q <= rsp_buf_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Result selection and output buses.
  always_comb begin
    load_data = align_load(raw_word, ent_q.ld_type, ent_q.lane);
    wdata     = is_load ? load_data : ent_q.result;
  end

  assign stall_req        = pending;
  assign wb_valid         = ent_q.valid & ~pending;
  assign wb_pc            = ent_q.pc;
  assign wb_rf_we         = wb_valid & ent_q.rf_we;
  assign wb_rf_waddr      = ent_q.rf_waddr;
  assign wb_rf_wdata      = wdata;
  assign fwd_we           = ent_q.valid & ent_q.rf_we;
  assign fwd_waddr        = ent_q.rf_waddr;
  assign fwd_wdata        = wdata;
  assign fwd_load_pending = pending;
  assign mem_err          = mem_err_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Self-checking bench for mem_stage_hs: directed scenarios plus a randomized
// instruction stream checked against a behavioural load-alignment model.
module tb_mem_stage_hs;
  localparam int PC_W    = 32;
  localparam int RF_AW   = 5;
  localparam int TIMEOUT = 4;

  logic             clk, rst, stall_mem, stall_wb, flush;
  logic             ex_valid, ex_mem_en, ex_rf_we;
  logic [PC_W-1:0]  ex_pc;
  logic [3:0]       ex_mem_we;
  logic [2:0]       ex_ld_type;
  logic [31:0]      ex_addr, ex_result;
  logic [RF_AW-1:0] ex_rf_waddr;
  logic             data_rsp_valid;
  logic [31:0]      data_sram_rdata;
  logic             stall_req, wb_valid, wb_rf_we, fwd_we, fwd_load_pending, mem_err;
  logic [PC_W-1:0]  wb_pc;
  logic [RF_AW-1:0] wb_rf_waddr, fwd_waddr;
  logic [31:0]      wb_rf_wdata, fwd_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_stage_hs #(.PC_W(PC_W), .RF_AW(RF_AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_mem_en(ex_mem_en), .ex_mem_we(ex_mem_we),
    .ex_ld_type(ex_ld_type), .ex_addr(ex_addr), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
    .data_rsp_valid(data_rsp_valid), .data_sram_rdata(data_sram_rdata),
    .stall_req(stall_req), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rf_we(wb_rf_we),
    .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata), .fwd_we(fwd_we),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_load_pending(fwd_load_pending),
    .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: load result from the word, the load type and the byte address.
  function automatic logic [31:0] ref_load(input int t, input logic [31:0] a,
                                           input logic [31:0] w);
    int unsigned lane, bytev, half;
    lane  = a % 4;
    bytev = (w >> (8 * lane)) & 32'hFF;
    half  = (w >> (16 * (lane / 2))) & 32'hFFFF;
    case (t)
      1:       return (bytev >= 128) ? bytev - 256 : bytev;
      2:       return bytev;
      3:       return (half >= 32768) ? half - 65536 : half;
      4:       return half;
      default: return w;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Let inputs settle, act as the pipeline controller for stall_mem, settle again.
  task automatic settle(input logic force_stall);
    #1;
    stall_mem = stall_req | stall_wb | force_stall;
    #1;
  endtask

  task automatic idle_inputs();
    stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; ex_pc = '0; ex_mem_en = 1'b0; ex_mem_we = '0; ex_ld_type = '0;
    ex_addr = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_result = '0;
    data_rsp_valid = 1'b0; data_sram_rdata = '0;
  endtask

  task automatic put_load(input logic [2:0] t, input logic [31:0] a,
                          input logic [PC_W-1:0] pc, input logic [RF_AW-1:0] rd);
    ex_valid = 1'b1; ex_pc = pc; ex_mem_en = 1'b1; ex_mem_we = 4'b0; ex_ld_type = t;
    ex_addr = a; ex_rf_we = 1'b1; ex_rf_waddr = rd; ex_result = $urandom;
  endtask

  task automatic put_alu(input logic [31:0] res);
    ex_valid = 1'b1; ex_pc = $urandom; ex_mem_en = 1'b0; ex_mem_we = 4'($urandom);
    ex_ld_type = 3'($urandom); ex_addr = $urandom; ex_rf_we = 1'b1;
    ex_rf_waddr = RF_AW'($urandom); ex_result = res;
  endtask

  // One load whose response arrives lat cycles after it enters the stage.
  task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd,
                         input int lat, input logic [31:0] expv, input string name);
    logic [PC_W-1:0]  pc;
    logic [RF_AW-1:0] dst;
    int stalls, pend, early;
    pc = $urandom; dst = RF_AW'($urandom);
    put_load(t, a, pc, dst);
    data_rsp_valid = 1'b0; settle(1'b0); tick();
    ex_valid = 1'b0;
    stalls = 0; pend = 0; early = 0;
    for (int i = 0; i < lat; i++) begin
      data_rsp_valid = 1'b0; data_sram_rdata = $urandom;
      settle(1'b0);
      stalls += int'(stall_req); pend += int'(fwd_load_pending); early += int'(wb_valid);
      tick();
    end
    data_rsp_valid = 1'b1; data_sram_rdata = rd;
    settle(1'b0);
    n_cmp++;
    if (stalls !== lat || pend !== lat || early !== 0) begin
      n_bad++;
      $display("FAIL %s wait: stall_req %0d pending %0d early_valid %0d, required %0d/%0d/0",
               name, stalls, pend, early, lat, lat);
    end
    n_cmp++;
    if ({stall_req, wb_valid, fwd_load_pending} !== 3'b010) begin
      n_bad++;
      $display("FAIL %s handshake: stall_req/wb_valid/pending=%b, required 010", name,
               {stall_req, wb_valid, fwd_load_pending});
    end
    n_cmp++;
    if (wb_rf_wdata !== expv || fwd_wdata !== expv) begin
      n_bad++;
      $display("FAIL %s data: wb %h fwd %h, required %h", name, wb_rf_wdata, fwd_wdata, expv);
    end
    n_cmp++;
    if (wb_pc !== pc || wb_rf_waddr !== dst || fwd_waddr !== dst || {wb_rf_we, fwd_we} !== 2'b11) begin
      n_bad++;
      $display("FAIL %s bus: pc %h waddr %0d we %b, required %h %0d 11", name, wb_pc,
               wb_rf_waddr, {wb_rf_we, fwd_we}, pc, dst);
    end
    tick();
    data_rsp_valid = 1'b0;
  endtask

  // ALU op or store: completes in the cycle it sits in the register.
  task automatic do_op(input bit store, input string name);
    logic [31:0] res;
    logic [PC_W-1:0] pc;
    logic we;
    logic [RF_AW-1:0] dst;
    res = $urandom; pc = $urandom; we = 1'($urandom); dst = RF_AW'($urandom);
    ex_valid = 1'b1; ex_pc = pc; ex_mem_en = store; ex_ld_type = 3'($urandom);
    ex_mem_we = store ? 4'($urandom_range(1, 15)) : 4'($urandom);
    ex_addr = $urandom; ex_rf_we = we; ex_rf_waddr = dst; ex_result = res;
    settle(1'b0); tick();
    ex_valid = 1'b0; data_rsp_valid = 1'($urandom); data_sram_rdata = $urandom;
    settle(1'b0);
    n_cmp++;
    if ({wb_valid, stall_req, fwd_load_pending} !== 3'b100 || wb_rf_wdata !== res || fwd_wdata !== res) begin
      n_bad++;
      $display("FAIL %s result: valid/stall/pend=%b data %h, required 100 %h", name,
               {wb_valid, stall_req, fwd_load_pending}, wb_rf_wdata, res);
    end
    n_cmp++;
    if (wb_rf_we !== we || fwd_we !== we || wb_rf_waddr !== dst || wb_pc !== pc) begin
      n_bad++;
      $display("FAIL %s bus: we %b/%b waddr %0d pc %h, required %b %0d %h", name, wb_rf_we,
               fwd_we, wb_rf_waddr, wb_pc, we, dst, pc);
    end
    tick();
    data_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; ex_valid = 1'b1; ex_mem_en = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = 5'd7;
    ex_pc = 32'h1234; ex_result = 32'hDEADBEEF; data_rsp_valid = 1'b1;
    tick(); tick(); #1;
    n_cmp++;
    if ({wb_valid, wb_rf_we, fwd_we, fwd_load_pending, stall_req, mem_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset flags: %b, required 000000",
               {wb_valid, wb_rf_we, fwd_we, fwd_load_pending, stall_req, mem_err});
    end
    n_cmp++;
    if (wb_pc !== '0 || wb_rf_waddr !== '0 || wb_rf_wdata !== '0 || fwd_waddr !== '0 || fwd_wdata !== '0) begin
      n_bad++;
      $display("FAIL reset buses: pc %h waddr %0d wdata %h fwd %0d/%h, required all 0",
               wb_pc, wb_rf_waddr, wb_rf_wdata, fwd_waddr, fwd_wdata);
    end
    rst = 1'b0; idle_inputs();
    tick();
  endtask

  task automatic test_zero_latency();
    do_load(3'd0, 32'h100, 32'h8899AABB, 0, 32'h8899AABB, "zero_lat_lw");
  endtask

  task automatic test_subword();
    do_load(3'd1, 32'h203, 32'h80FF7F01, 0, 32'hFFFFFF80, "lb_lane3");
    do_load(3'd2, 32'h201, 32'h80FF7F01, 1, 32'h0000007F, "lbu_lane1");
    do_load(3'd3, 32'h202, 32'h80FF7F01, 0, 32'hFFFF80FF, "lh_lane2");
    do_load(3'd4, 32'h200, 32'h80FF7F01, 2, 32'h00007F01, "lhu_lane0");
    do_load(3'd3, 32'h203, 32'h80FF7F01, 0, 32'hFFFF80FF, "lh_misaligned");
    do_load(3'd7, 32'h202, 32'h80FF7F01, 0, 32'h80FF7F01, "undef_as_lw");
  endtask

  task automatic test_wait_latency();
    do_load(3'd0, 32'h340, 32'h13572468, 3, 32'h13572468, "wait_3");
  endtask

  task automatic test_alu_store();
    do_op(1'b0, "alu");
    do_op(1'b1, "store");
  endtask

  task automatic test_hold();
    logic [31:0] alu_res;
    alu_res = $urandom;
    put_load(3'd4, 32'h2002, 32'h400, 5'd9);
    settle(1'b0); tick();
    // Response arrives while WB is stalled; a younger ALU op waits in EX.
    put_alu(alu_res);
    stall_wb = 1'b1; data_rsp_valid = 1'b1; data_sram_rdata = 32'hCAFE1234;
    settle(1'b0);
    n_cmp++;
    if ({stall_req, wb_valid} !== 2'b01 || wb_rf_wdata !== 32'h0000CAFE) begin
      n_bad++;
      $display("FAIL hold_arrive: stall/valid %b data %h, required 01 0000cafe",
               {stall_req, wb_valid}, wb_rf_wdata);
    end
    tick();
    data_rsp_valid = 1'b1; data_sram_rdata = 32'h55555555;
    settle(1'b0);
    n_cmp++;
    if ({stall_req, wb_valid, fwd_load_pending} !== 3'b010 || wb_rf_wdata !== 32'h0000CAFE || wb_pc !== 32'h400) begin
      n_bad++;
      $display("FAIL hold_stable: stall/valid/pend %b data %h pc %h, required 010 0000cafe 400",
               {stall_req, wb_valid, fwd_load_pending}, wb_rf_wdata, wb_pc);
    end
    tick();
    stall_wb = 1'b0; data_rsp_valid = 1'b0; data_sram_rdata = $urandom;
    settle(1'b0);
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_rf_wdata !== 32'h0000CAFE) begin
      n_bad++;
      $display("FAIL hold_retire: valid %b data %h, required 1 0000cafe", wb_valid, wb_rf_wdata);
    end
    tick();
    ex_valid = 1'b0;
    settle(1'b0);
    n_cmp++;
    if ({wb_valid, stall_req} !== 2'b10 || wb_rf_wdata !== alu_res) begin
      n_bad++;
      $display("FAIL hold_next: valid/stall %b data %h, required 10 %h",
               {wb_valid, stall_req}, wb_rf_wdata, alu_res);
    end
    tick();
    do_load(3'd1, 32'h501, 32'h0000C300, 0, 32'hFFFFFFC3, "after_hold");
  endtask

  task automatic test_flush_bubble();
    logic [31:0] r1;
    put_load(3'd0, 32'h600, 32'h600, 5'd3);
    settle(1'b0); tick();
    ex_valid = 1'b0;
    settle(1'b0);
    n_cmp++;
    if (stall_req !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_pre: stall_req %b, required 1", stall_req);
    end
    tick();
    put_alu($urandom); flush = 1'b1;
    settle(1'b0); tick();
    flush = 1'b0; ex_valid = 1'b0; data_rsp_valid = 1'b1; data_sram_rdata = 32'hA5A5A5A5;
    settle(1'b0);
    n_cmp++;
    if ({wb_valid, wb_rf_we, fwd_we, stall_req, fwd_load_pending} !== 5'b0) begin
      n_bad++;
      $display("FAIL flush_late_rsp: valid/we/fwd/stall/pend %b, required 00000",
               {wb_valid, wb_rf_we, fwd_we, stall_req, fwd_load_pending});
    end
    tick();
    data_rsp_valid = 1'b0;
    do_load(3'd2, 32'h602, 32'h00990000, 2, 32'h00000099, "after_flush");
    // Bubble: upstream stalled, WB free.
    r1 = $urandom;
    put_alu(r1);
    settle(1'b0); tick();
    put_alu($urandom);
    settle(1'b1);
    n_cmp++;
    if (wb_valid !== 1'b1 || wb_rf_wdata !== r1) begin
      n_bad++;
      $display("FAIL bubble_pre: valid %b data %h, required 1 %h", wb_valid, wb_rf_wdata, r1);
    end
    tick();
    ex_valid = 1'b0;
    settle(1'b0);
    n_cmp++;
    if ({wb_valid, wb_rf_we, fwd_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL bubble: valid/we/fwd %b, required 000", {wb_valid, wb_rf_we, fwd_we});
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind, t, lat;
      logic [31:0] a, w;
      kind = $urandom_range(0, 3);
      if (kind == 0) do_op(1'b0, "rand_alu");
      else if (kind == 1) do_op(1'b1, "rand_store");
      else begin
        t = $urandom_range(0, 7); lat = $urandom_range(0, TIMEOUT - 1);
        a = $urandom; w = $urandom;
        do_load(3'(t), a, w, lat, ref_load(t, a, w), "rand_load");
      end
    end
    n_cmp++;
    if (mem_err !== 1'b0) begin
      n_bad++;
      $display("FAIL no_spurious_err: mem_err %b, required 0", mem_err);
    end
  endtask

  task automatic test_timeout();
    int stalls, errs;
    put_load(3'd0, 32'h700, 32'h700, 5'd4);
    settle(1'b0); tick();
    ex_valid = 1'b0; stalls = 0; errs = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      data_rsp_valid = 1'b0; data_sram_rdata = $urandom;
      settle(1'b0);
      stalls += int'(stall_req); errs += int'(mem_err);
      tick();
    end
    data_sram_rdata = 32'hFFFFFFFF;
    settle(1'b0);
    n_cmp++;
    if (stalls !== TIMEOUT || errs !== 0 || {stall_req, wb_valid} !== 2'b01 || wb_rf_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL timeout_complete: stalls %0d errs %0d stall/valid %b data %h, required %0d 0 01 0",
               stalls, errs, {stall_req, wb_valid}, wb_rf_wdata, TIMEOUT);
    end
    tick();
    settle(1'b0);
    n_cmp++;
    if (mem_err !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_err: mem_err %b, required 1", mem_err);
    end
    do_op(1'b0, "post_timeout_alu");
    do_load(3'd0, 32'h704, 32'h0BADF00D, 1, 32'h0BADF00D, "post_timeout_load");
    settle(1'b0);
    n_cmp++;
    if (mem_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: mem_err %b, required 1", mem_err);
    end
    rst = 1'b1;
    tick(); #1;
    n_cmp++;
    if (mem_err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_reset: mem_err %b, required 0", mem_err);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_zero_latency();
    test_subword();
    test_wait_latency();
    test_alu_store();
    test_hold();
    test_flush_bubble();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
